// File: rtl/bus_req_agent.sv
`default_nettype none
// ============================================================================
// Module   : bus_req_agent
// Purpose  : Requester-side agent for one req/gnt port of a 4-way round-robin
//            bus arbiter. Buffers client words in a circular FIFO, raises req,
//            streams up to MAX_BURST beats per tenure once granted, then drops
//            req so the arbiter can rotate. Flags request timeouts and grant
//            loss with single-cycle registered pulses.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            wr_valid_i/wr_data_i/wr_ready_o - client write stream
//            gnt_i / req_o      - arbiter handshake
//            bus_valid_o/bus_data_o - beat on shared bus (data 0 when idle)
//            burst_done_o, gnt_lost_o, timeout_o - tenure status pulses
//            fifo_count_o       - words currently buffered
// Revision : 1.0 - initial release
// ============================================================================
module bus_req_agent #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     gnt_i,
  output logic                     req_o,
  output logic                     bus_valid_o,
  output logic [DATA_W-1:0]        bus_data_o,
  output logic                     burst_done_o,
  output logic                     gnt_lost_o,
  output logic                     timeout_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int WAIT_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0]  c_DEPTH     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  c_ONE       = CNT_W'(1);
  localparam logic [BEAT_W-1:0] c_BEAT_MAX  = BEAT_W'(MAX_BURST);
  localparam logic [BEAT_W-1:0] c_BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              burst_done_q, burst_done_d;
  logic              gnt_lost_q, gnt_lost_d;
  logic              timeout_q, timeout_d;

  logic w_push, w_req, w_beat, w_last, w_nonempty;

  assign w_nonempty = (count_q != '0);
  assign w_push     = wr_valid_i & wr_ready_o;
  assign w_req      = (state_q == S_REQ) | (state_q == S_XFER);
  assign w_beat     = w_req & gnt_i & w_nonempty & (beat_q < c_BEAT_MAX);
  // A push landing with the pop of the last word keeps the burst going.
  assign w_last     = w_beat & ((beat_q == c_BEAT_LAST) | ((count_q == c_ONE) & ~w_push));

  assign wr_ready_o   = (count_q < c_DEPTH);
  assign req_o        = w_req;
  assign bus_valid_o  = w_beat;
  assign bus_data_o   = w_beat ? mem_q[rd_ptr_q] : '0;
  assign burst_done_o = burst_done_q;
  assign gnt_lost_o   = gnt_lost_q;
  assign timeout_o    = timeout_q;
  assign fifo_count_o = count_q;

  // FIFO storage carries no reset; stale entries are never observable
  // because bus_data is masked whenever no beat is issued.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_beat})
      2'b10:   count_d = count_q + c_ONE;
      2'b01:   count_d = count_q - c_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    beat_d       = beat_q;
    burst_done_d = 1'b0;
    gnt_lost_d   = 1'b0;
    timeout_d    = 1'b0;
    if (w_beat) begin
      beat_d = beat_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        beat_d = '0;
        if (w_nonempty) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt_i) begin
          // The first beat is issued in this cycle; it may also be the last.
          if (w_last) begin
            state_d      = S_GAP;
            burst_done_d = 1'b1;
          end else begin
            state_d = S_XFER;
          end
        end else if (wait_q == c_WAIT_LAST) begin
          state_d   = S_GAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_XFER: begin
        if (!gnt_i) begin
          state_d    = S_GAP;
          gnt_lost_d = 1'b1;
        end else if (w_last) begin
          state_d      = S_GAP;
          burst_done_d = 1'b1;
        end
      end
      default: begin
        // Hold req low until the arbiter releases the grant. Re-request
        // directly when data is waiting so the gap between tenures is two
        // cycles; the counters are cleared here as IDLE would do.
        if (!gnt_i) begin
          wait_d  = '0;
          beat_d  = '0;
          state_d = w_nonempty ? S_REQ : S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wait_q       <= '0;
      beat_q       <= '0;
      burst_done_q <= 1'b0;
      gnt_lost_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      beat_q       <= beat_d;
      burst_done_q <= burst_done_d;
      gnt_lost_q   <= gnt_lost_d;
      timeout_q    <= timeout_d;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_beat) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_req_agent.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_req_agent
// Purpose  : Scoreboard bench for bus_req_agent with a looped-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_req_agent;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       gnt;
  logic       req;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       burst_done;
  logic       gnt_lost;
  logic       timeout;
  logic [2:0] fifo_count;

  bus_req_agent #(
    .DATA_W(8), .DEPTH(4), .MAX_BURST(4), .TIMEOUT(16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid_i  (wr_valid),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .gnt_i       (gnt),
    .req_o       (req),
    .bus_valid_o (bus_valid),
    .bus_data_o  (bus_data),
    .burst_done_o(burst_done),
    .gnt_lost_o  (gnt_lost),
    .timeout_o   (timeout),
    .fifo_count_o(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter model: grant registered from req while enabled.
  logic gnt_en;
  always @(posedge clk) begin
    if (rst) gnt <= 1'b0;
    else     gnt <= gnt_en & req;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  int         ten_q [$];
  int beats = 0, ten_beats = 0, bd_cnt = 0, gl_cnt = 0, to_cnt = 0;
  int rise_cnt = 0, hi_run = 0, low_run = 0, last_low = 0, to_run = 0;
  logic req_prev = 1'b0;

  // Monitor: sampled mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_valid) begin
        if (exp_q.size() == 0) chk("bus_extra_beat", 32'(bus_data), 32'hFFFF);
        else                   chk("bus_data", 32'(bus_data), 32'(exp_q.pop_front()));
        beats++;
        ten_beats++;
      end else begin
        chk("bus_data_mask", 32'(bus_data), 32'h0);
      end
      if (burst_done) begin
        bd_cnt++;
        ten_q.push_back(ten_beats);
        ten_beats = 0;
      end
      if (gnt_lost) begin
        gl_cnt++;
        ten_beats = 0;
      end
      if (timeout) begin
        to_cnt++;
        to_run = hi_run;
      end
      if (req && !req_prev) begin
        rise_cnt++;
        last_low = low_run;
        low_run  = 0;
        hi_run   = 0;
      end
      if (req) hi_run++;
      else     low_run++;
      req_prev = req;
    end else begin
      ten_beats = 0;
      req_prev  = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one word until accepted; scoreboard entry pushed on acceptance.
  task automatic put(input logic [7:0] d);
    bit done;
    done     = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 64 && !done; i++) begin
      done = wr_ready;
      @(posedge clk);
      if (done) exp_q.push_back(d);
      #2;
    end
    wr_valid = 1'b0;
    if (!done) chk("put_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int b0, g0, r0, t0, n0;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; gnt_en = 1'b0;
    repeat (2) tick();
    chk("rst_req",        32'(req),        32'd0);
    chk("rst_bus_valid",  32'(bus_valid),  32'd0);
    chk("rst_bus_data",   32'(bus_data),   32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_wr_ready",   32'(wr_ready),   32'd1);
    chk("rst_pulses",     32'({burst_done, gnt_lost, timeout}), 32'd0);
    rst = 1'b0;
    tick();

    // Three-word burst with grant looped back
    gnt_en = 1'b1;
    b0 = bd_cnt; ten_q.delete();
    put(8'hA1);
    chk("t1_count_after_w0", 32'(fifo_count), 32'd1);
    chk("t1_req_low_e0",     32'(req),        32'd0);
    put(8'hA2);
    chk("t1_req_high_e1",    32'(req),        32'd1);
    put(8'hA3);
    for (int i = 0; i < 30 && bd_cnt == b0; i++) tick();
    chk("t1_burst_done_cnt", 32'(bd_cnt - b0), 32'd1);
    chk("t1_burst_len",      32'(ten_q.size() > 0 ? ten_q[0] : -1), 32'd3);
    chk("t1_pulse_width",    32'(burst_done), 32'd0);
    chk("t1_req_dropped",    32'(req),        32'd0);
    chk("t1_fifo_empty",     32'(fifo_count), 32'd0);

    // Six words split across two tenures by MAX_BURST
    repeat (4) tick();
    b0 = bd_cnt; r0 = rise_cnt; ten_q.delete();
    for (int k = 0; k < 6; k++) put(8'hB0 + 8'(k));
    for (int i = 0; i < 60 && (bd_cnt - b0) < 2; i++) tick();
    chk("t2_burst_done_cnt", 32'(bd_cnt - b0), 32'd2);
    chk("t2_first_len",      32'(ten_q.size() > 0 ? ten_q[0] : -1), 32'd4);
    chk("t2_second_len",     32'(ten_q.size() > 1 ? ten_q[1] : -1), 32'd2);
    chk("t2_req_rises",      32'(rise_cnt - r0), 32'd2);
    chk("t2_fifo_empty",     32'(fifo_count), 32'd0);

    // Request timeout with grant withheld
    repeat (4) tick();
    gnt_en = 1'b0;
    t0 = to_cnt; r0 = rise_cnt; b0 = bd_cnt; ten_q.delete();
    put(8'hC0);
    for (int i = 0; i < 40 && to_cnt == t0; i++) tick();
    chk("t3_timeout_cnt",    32'(to_cnt - t0), 32'd1);
    chk("t3_req_cycles",     32'(to_run),      32'd16);
    chk("t3_pulse_width",    32'(timeout),     32'd0);
    for (int i = 0; i < 10 && (rise_cnt - r0) < 2; i++) tick();
    chk("t3_rerequest",      32'(rise_cnt - r0), 32'd2);
    chk("t3_req_low_cycles", 32'(last_low),      32'd1);
    chk("t3_word_retained",  32'(fifo_count),    32'd1);
    gnt_en = 1'b1;
    for (int i = 0; i < 20 && bd_cnt == b0; i++) tick();
    chk("t3_drain_len",      32'(ten_q.size() > 0 ? ten_q[0] : -1), 32'd1);

    // Grant dropped after the second beat
    repeat (4) tick();
    gnt_en = 1'b0;
    for (int k = 0; k < 4; k++) put(8'hD0 + 8'(k));
    chk("t4_preload",        32'(fifo_count), 32'd4);
    g0 = gl_cnt; b0 = bd_cnt; n0 = beats; ten_q.delete();
    gnt_en = 1'b1;
    for (int i = 0; i < 20 && beats == n0; i++) tick();
    gnt_en = 1'b0;
    for (int i = 0; i < 10 && gl_cnt == g0; i++) tick();
    chk("t4_gnt_lost_cnt",   32'(gl_cnt - g0), 32'd1);
    chk("t4_no_burst_done",  32'(bd_cnt - b0), 32'd0);
    chk("t4_count_left",     32'(fifo_count),  32'd2);
    chk("t4_beats_sent",     32'(beats - n0),  32'd2);
    gnt_en = 1'b1;
    for (int i = 0; i < 20 && bd_cnt == b0; i++) tick();
    chk("t4_resume_len",     32'(ten_q.size() > 0 ? ten_q[0] : -1), 32'd2);
    chk("t4_fifo_empty",     32'(fifo_count), 32'd0);

    // Full FIFO, then push every cycle during a tenure
    repeat (4) tick();
    gnt_en = 1'b0;
    for (int k = 0; k < 4; k++) put(8'hE0 + 8'(k));
    chk("t5_full_count",     32'(fifo_count), 32'd4);
    chk("t5_full_not_ready", 32'(wr_ready),   32'd0);
    b0 = bd_cnt; ten_q.delete();
    gnt_en = 1'b1;
    put(8'hE4);
    put(8'hE5);
    chk("t5_count_steady_a", 32'(fifo_count), 32'd3);
    put(8'hE6);
    chk("t5_count_steady_b", 32'(fifo_count), 32'd3);
    put(8'hE7);
    for (int i = 0; i < 60 && (bd_cnt - b0) < 2; i++) tick();
    chk("t5_first_len",      32'(ten_q.size() > 0 ? ten_q[0] : -1), 32'd4);
    chk("t5_drained",        32'(exp_q.size()), 32'd0);

    // Reset in the middle of a tenure
    repeat (4) tick();
    n0 = beats;
    put(8'hF0); put(8'hF1); put(8'hF2);
    for (int i = 0; i < 20 && beats == n0; i++) tick();
    rst = 1'b1;
    tick();
    chk("t6_req",            32'(req),        32'd0);
    chk("t6_bus_valid",      32'(bus_valid),  32'd0);
    chk("t6_fifo_count",     32'(fifo_count), 32'd0);
    chk("t6_wr_ready",       32'(wr_ready),   32'd1);
    exp_q.delete();
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_stays_idle",     32'({req, fifo_count}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
